segmented_mem_access_unit: RTL and testbench
============================================

Name: segmented_mem_access_unit

Overview:
- Consumer side of the segment:pointer address path.
- Accepts segment/offset access requests from the core and forms the 20-bit physical address (segment + offset).
- Checks overflow and the write-protected region, then runs a single-outstanding transaction on the memory bus with an ack timeout.
- Returns read data or a fault code to the core through a valid/ready response channel.

Parameters:
- ADDR_W, 20, physical/segment/offset width.
- DATA_W, 16, data bus width.
- TIMEOUT, 15, max BUS cycles waiting for mem_ack before fault.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- req_valid  input  1  core request valid.
- req_ready  output  1  unit can accept request.
- req_write  input  1  1 = write, 0 = read.
- req_segment  input  ADDR_W  segment base.
- req_offset  input  ADDR_W  pointer/offset.
- req_wdata  input  DATA_W  write data.
- wp_base  input  ADDR_W  write-protect region start (inclusive).
- wp_limit  input  ADDR_W  write-protect region end (inclusive).
- mem_req  output  1  bus request, held until ack or timeout.
- mem_we  output  1  bus write enable.
- mem_addr  output  ADDR_W  physical address.
- mem_wdata  output  DATA_W  bus write data.
- mem_ack  input  1  bus completion; rdata valid same cycle.
- mem_rdata  input  DATA_W  bus read data.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  core accepts response.
- rsp_rdata  output  DATA_W  read data; 0 for writes/faults.
- rsp_fault  output  2  0 OK, 1 write-protect, 2 address overflow, 3 bus timeout.

Behaviour:
- Reset (rst_n low at clk edge): state IDLE, req_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_fault=0, timeout counter=0. Reset mid-transaction abandons it; no response is issued.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch we, wdata, mem_addr = low ADDR_W bits of (segment + offset), and fault:
    - fault = 2 if the (ADDR_W+1)-bit sum has its carry set;
    - else fault = 1 if write and wp_base <= addr <= wp_limit;
    - else 0.
    - Go to RESP if fault != 0, else BUS.
  - BUS: mem_req=1, mem_we/mem_addr/mem_wdata stable. Counter increments each BUS cycle.
    - On mem_ack: capture mem_rdata (reads only; 0 for writes), fault=0, go to RESP.
    - Else if counter == TIMEOUT-1: fault=3, go to RESP.
    - Ack on the timeout cycle: ack wins.
  - RESP: rsp_valid=1, rsp_rdata/rsp_fault stable. On rsp_ready, go to IDLE, clear counter.
- req_ready=1 only in IDLE; no pipelining, one outstanding request.
- Latency:
  - Accept at edge N; mem_req high in cycle N+1.
  - mem_ack in cycle M gives rsp_valid in cycle M+1.
  - A faulted request has rsp_valid in cycle N+1 and never asserts mem_req.
- Protection: when wp_base > wp_limit the region is empty. Reads are never protected. wp_* are sampled only at accept.
- Overflow faults apply to both reads and writes.
- mem_req deasserts the cycle after ack or timeout. A late mem_ack in IDLE or RESP is ignored.

Decomposition:
- Shared package (cpu_mem_pkg):
  - ADDR_W and DATA_W constants;
  - fault code constants FAULT_NONE, FAULT_WP, FAULT_OVF, FAULT_TIMEOUT;
  - FSM state encoding.
- One sub-module, seg_addr_check: combinational sum, carry, and protect-range compare producing addr and fault code. The FSM and timeout counter stay in the top.

Test Plan:
- Read, no fault: segment=0x01000, offset=0x00234, write=0; mem_ack after 2 BUS cycles with rdata=0xBEEF -> mem_addr=0x01234 with mem_we=0; rsp_fault=0, rsp_rdata=0xBEEF one cycle after ack.
- Write-protect: wp_base=0x00000, wp_limit=0x0FFFF; write to seg=0x00000, off=0x00100 -> mem_req never asserted; rsp_fault=1 the cycle after accept. Same address as a read -> bus read issued, fault 0.
- Overflow: seg=0xFFFF0, off=0x00020 -> rsp_fault=2, no bus activity. seg=0xFFFF0, off=0x0000F -> addr 0xFFFFF issued normally.
- Timeout: mem_ack held 0 -> mem_req high exactly 15 cycles, then rsp_fault=3, rsp_rdata=0. Ack on cycle 15 -> fault 0.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata, rsp_fault stable and req_ready=0 throughout. Next request accepted only after the handshake.
- Reset mid-BUS: drop rst_n while mem_req=1 -> next cycle mem_req=0, rsp_valid=0, req_ready=1. A subsequent read completes normally.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared widths, fault codes and FSM encoding for the segmented memory access unit.
package cpu_mem_pkg;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 16;

    typedef logic [1:0] fault_t;

    localparam fault_t FAULT_NONE    = 2'd0;
    localparam fault_t FAULT_WP      = 2'd1;
    localparam fault_t FAULT_OVF     = 2'd2;
    localparam fault_t FAULT_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StResp
    } state_e;

endpackage

// File: rtl/seg_addr_check.sv
// Forms the physical address from segment + offset and classifies overflow / write-protect faults.
module seg_addr_check
    import cpu_mem_pkg::*;
#(
    parameter int unsigned AddrW = cpu_mem_pkg::ADDR_W
) (
    input  logic [AddrW-1:0] segment_i,
    input  logic [AddrW-1:0] offset_i,
    input  logic             write_i,
    input  logic [AddrW-1:0] wp_base_i,
    input  logic [AddrW-1:0] wp_limit_i,
    output logic [AddrW-1:0] addr_o,
    output logic [1:0]       fault_o
);

    logic [AddrW:0] sum;
    logic           in_wp;

    assign sum    = {1'b0, segment_i} + {1'b0, offset_i};
    assign addr_o = sum[AddrW-1:0];

    // An inverted range (base > limit) can never satisfy both bounds, so it is empty.
    assign in_wp = (addr_o >= wp_base_i) && (addr_o <= wp_limit_i);

    always_comb begin
        fault_o = FAULT_NONE;
        if (sum[AddrW]) begin
            fault_o = FAULT_OVF;
        end else if (write_i && in_wp) begin
            fault_o = FAULT_WP;
        end
    end

endmodule

// File: rtl/segmented_mem_access_unit.sv
// Accepts segment:offset requests, runs one bus transaction with an ack timeout and returns
// read data or a fault code on a valid/ready response channel.
module segmented_mem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = cpu_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W  = cpu_mem_pkg::DATA_W,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_segment,
    input  logic [ADDR_W-1:0] req_offset,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [ADDR_W-1:0] wp_base,
    input  logic [ADDR_W-1:0] wp_limit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_fault
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        fault_q, fault_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [ADDR_W-1:0] chk_addr;
    logic [1:0]        chk_fault;

    seg_addr_check #(
        .AddrW (ADDR_W)
    ) u_seg_addr_check (
        .segment_i  (req_segment),
        .offset_i   (req_offset),
        .write_i    (req_write),
        .wp_base_i  (wp_base),
        .wp_limit_i (wp_limit),
        .addr_o     (chk_addr),
        .fault_o    (chk_fault)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d    = req_write;
                    addr_d  = chk_addr;
                    wdata_d = req_wdata;
                    fault_d = chk_fault;
                    rdata_d = '0;
                    cnt_d   = '0;
                    state_d = (chk_fault != FAULT_NONE) ? StResp : StBus;
                end
            end
            StBus: begin
                cnt_d = cnt_q + CntW'(1);
                // Ack takes priority over a timeout landing in the same cycle.
                if (mem_ack) begin
                    rdata_d = we_q ? '0 : mem_rdata;
                    fault_d = FAULT_NONE;
                    state_d = StResp;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    fault_d = FAULT_TIMEOUT;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= FAULT_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign mem_req   = (state_q == StBus);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_fault = fault_q;

endmodule

// File: tb/tb_segmented_mem_access_unit.sv
// Directed scoreboard bench for segmented_mem_access_unit.
module tb_segmented_mem_access_unit;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [19:0] req_segment;
    logic [19:0] req_offset;
    logic [15:0] req_wdata;
    logic [19:0] wp_base;
    logic [19:0] wp_limit;
    logic        mem_req;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic [1:0]  rsp_fault;

    typedef struct packed {
        logic [15:0] rdata;
        logic [1:0]  fault;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    segmented_mem_access_unit #(
        .ADDR_W  (20),
        .DATA_W  (16),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_segment (req_segment),
        .req_offset  (req_offset),
        .req_wdata   (req_wdata),
        .wp_base     (wp_base),
        .wp_limit    (wp_limit),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_fault   (rsp_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every accepted response against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got fault %0d rdata 0x%0h required none",
                         rsp_fault, rsp_rdata);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                check("rsp_fault", 32'(rsp_fault), 32'(e.fault));
            end
        end
    end

    task automatic issue(input logic w, input logic [19:0] seg, input logic [19:0] off,
                         input logic [15:0] wd);
        req_valid   = 1'b1;
        req_write   = w;
        req_segment = seg;
        req_offset  = off;
        req_wdata   = wd;
        check("req_ready_at_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // ack_cyc: BUS cycle (1-based) carrying mem_ack, 0 = never ack.
    task automatic transact(input logic w, input logic [19:0] seg, input logic [19:0] off,
                            input logic [15:0] wd, input int ack_cyc, input logic [15:0] mrd,
                            input logic [19:0] exp_addr, input logic [15:0] exp_rdata,
                            input logic [1:0] exp_fault, input int bp);
        rsp_t e;
        logic exp_bus;
        int   cycles;
        e.rdata = exp_rdata;
        e.fault = exp_fault;
        exp_q.push_back(e);
        exp_bus   = (exp_fault == 2'd0) || (exp_fault == 2'd3);
        rsp_ready = (bp == 0);
        mem_rdata = mrd;
        issue(w, seg, off, wd);
        if (exp_bus) begin
            cycles = 0;
            while (mem_req && cycles < 40) begin
                cycles++;
                if (cycles == 1) begin
                    check("mem_addr", 32'(mem_addr), 32'(exp_addr));
                    check("mem_we", 32'(mem_we), 32'(w));
                    if (w) check("mem_wdata", 32'(mem_wdata), 32'(wd));
                end
                if (cycles == ack_cyc) mem_ack = 1'b1;
                @(posedge clk);
                #1;
                mem_ack = 1'b0;
            end
            check("mem_req_cycles", 32'(cycles), 32'((ack_cyc != 0) ? ack_cyc : TIMEOUT));
        end else begin
            check("no_mem_req", 32'(mem_req), 32'd0);
        end
        check("rsp_valid_latency", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < bp; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
            check("bp_rsp_fault", 32'(rsp_fault), 32'(exp_fault));
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_mem_req", 32'(mem_req), 32'd0);
            req_valid = 1'b1;
            req_write = 1'b0;
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("idle_after_rsp", 32'(req_ready), 32'd1);
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("mem_req_idle", 32'(mem_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_segment = '0;
        req_offset  = '0;
        req_wdata   = '0;
        wp_base     = 20'h00000;
        wp_limit    = 20'h0FFFF;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        rsp_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain read, ack in second BUS cycle.
        transact(1'b0, 20'h01000, 20'h00234, 16'h0000, 2, 16'hBEEF,
                 20'h01234, 16'hBEEF, 2'd0, 0);
        // Write into protected region, then the same address as a read.
        transact(1'b1, 20'h00000, 20'h00100, 16'h1234, 1, 16'h0000,
                 20'h00100, 16'h0000, 2'd1, 0);
        transact(1'b0, 20'h00000, 20'h00100, 16'h0000, 1, 16'h5A5A,
                 20'h00100, 16'h5A5A, 2'd0, 0);
        // Write outside region: rdata returns 0 even though the bus drives data.
        transact(1'b1, 20'h20000, 20'h00010, 16'hCAFE, 3, 16'hFFFF,
                 20'h20010, 16'h0000, 2'd0, 0);
        // Overflow read and write (wrapped addr 0x00010 is protected; overflow wins).
        transact(1'b0, 20'hFFFF0, 20'h00020, 16'h0000, 1, 16'h0000,
                 20'h00010, 16'h0000, 2'd2, 0);
        transact(1'b1, 20'hFFFF0, 20'h00020, 16'h7777, 1, 16'h0000,
                 20'h00010, 16'h0000, 2'd2, 0);
        transact(1'b0, 20'hFFFF0, 20'h0000F, 16'h0000, 1, 16'h0F0F,
                 20'hFFFFF, 16'h0F0F, 2'd0, 0);
        // Timeout, then ack on the last allowed cycle.
        transact(1'b0, 20'h30000, 20'h00000, 16'h0000, 0, 16'hDEAD,
                 20'h30000, 16'h0000, 2'd3, 0);
        transact(1'b0, 20'h30000, 20'h00004, 16'h0000, TIMEOUT, 16'h1357,
                 20'h30004, 16'h1357, 2'd0, 0);
        // Empty (inverted) region never protects.
        wp_base  = 20'h50000;
        wp_limit = 20'h4FFFF;
        transact(1'b1, 20'h50000, 20'h00000, 16'hAAAA, 1, 16'h0000,
                 20'h50000, 16'h0000, 2'd0, 0);
        // Inclusive bounds.
        wp_base  = 20'h40000;
        wp_limit = 20'h40010;
        transact(1'b1, 20'h40000, 20'h00010, 16'h1111, 1, 16'h0000,
                 20'h40010, 16'h0000, 2'd1, 0);
        transact(1'b1, 20'h40000, 20'h00000, 16'h1112, 1, 16'h0000,
                 20'h40000, 16'h0000, 2'd1, 0);
        transact(1'b1, 20'h40000, 20'h00011, 16'h2222, 1, 16'h0000,
                 20'h40011, 16'h0000, 2'd0, 0);
        transact(1'b1, 20'h30000, 20'h0FFFF, 16'h3333, 2, 16'h0000,
                 20'h3FFFF, 16'h0000, 2'd0, 0);
        // Backpressure for 5 cycles.
        transact(1'b0, 20'h00100, 20'h00001, 16'h0000, 1, 16'h2468,
                 20'h00101, 16'h2468, 2'd0, 5);
        transact(1'b1, 20'h40000, 20'h00008, 16'h4444, 1, 16'h0000,
                 20'h40008, 16'h0000, 2'd1, 5);

        // Reset in the middle of a bus transaction: no response may appear.
        issue(1'b0, 20'h60000, 20'h00005, 16'h0000);
        check("mid_bus_mem_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_bus_mem_req", 32'(mem_req), 32'd0);
        check("rst_bus_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_bus_req_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        transact(1'b0, 20'h60000, 20'h00005, 16'h0000, 2, 16'h9876,
                 20'h60005, 16'h9876, 2'd0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
